// File: rtl/seven_seg_pkg.sv
// Shared definitions for the multiplexed seven-segment display driver.
//   SEG_LUT    : hex digit -> active-high segment pattern {g,f,e,d,c,b,a}
//   SEG_BLANK  : active-low cathode pattern with every segment off
//   cnt_width  : bit width needed for a 0..period-1 slot counter
package seven_seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Entry 15 is leftmost so SEG_LUT[h] returns the pattern for digit h.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic int cnt_width(input int period);
        return (period > 1) ? $clog2(period) : 1;
    endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational hex digit to seven-segment decoder.
//   hex   : 4-bit digit value
//   blank : forces every segment off
//   seg   : active-high segment pattern {g,f,e,d,c,b,a}
module hex_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] hex,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_LUT[hex];
        if (blank) begin
            seg = 7'h00;
        end
    end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed N-digit common-anode display driver.
//   clk_in, rst_n_in : system clock, asynchronous active-low reset
//   en_in            : scan enable; low freezes the scan and turns all anodes off
//   val_in, dp_in    : packed hex digits and decimal-point requests (digit 0 rightmost)
//   load_in          : captures val_in/dp_in/blank_lz_in; shown from the next frame on
//   blank_lz_in      : leading-zero suppression enable
//   cat_out, dp_out  : active-low segment and decimal-point cathodes
//   an_out           : active-low digit anodes, at most one low
//   frame_done_out   : one-cycle pulse after each complete scan
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int COUNT_PERIOD = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    en_in,
    input  logic [4*NUM_DIGITS-1:0] val_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load_in,
    input  logic                    blank_lz_in,
    output logic [6:0]              cat_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_done_out
);

    localparam int CW = cnt_width(COUNT_PERIOD);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_LAST  = CW'(COUNT_PERIOD - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic                    tc;
    logic                    wrap;

    logic [4*NUM_DIGITS-1:0] shadow_val;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic                    shadow_lz;
    logic                    pending;
    logic [4*NUM_DIGITS-1:0] act_val;
    logic [NUM_DIGITS-1:0]   act_dp;
    logic                    act_lz;

    logic [NUM_DIGITS-1:0]   lz_mask;
    logic                    zero_above;
    logic [3:0]              cur_hex;
    logic [6:0]              cur_seg;
    logic [NUM_DIGITS-1:0]   an_next;

    assign tc   = (cnt == CNT_LAST);
    assign wrap = en_in && tc && (idx == IDX_LAST);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt <= '0;
            idx <= '0;
        end else if (en_in) begin
            if (tc) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Shadow/active double buffer: the displayed value only changes on a
    // frame boundary, or immediately when the scan is stopped.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            shadow_val <= '0;
            shadow_dp  <= '0;
            shadow_lz  <= 1'b0;
            pending    <= 1'b0;
            act_val    <= '0;
            act_dp     <= '0;
            act_lz     <= 1'b0;
        end else if (load_in && wrap) begin
            act_val <= val_in;
            act_dp  <= dp_in;
            act_lz  <= blank_lz_in;
            pending <= 1'b0;
        end else if (load_in) begin
            shadow_val <= val_in;
            shadow_dp  <= dp_in;
            shadow_lz  <= blank_lz_in;
            pending    <= 1'b1;
        end else if (pending && (wrap || !en_in)) begin
            act_val <= shadow_val;
            act_dp  <= shadow_dp;
            act_lz  <= shadow_lz;
            pending <= 1'b0;
        end
    end

    // Digit i is a leading zero when it and every digit above it are zero.
    // Digit 0 is always shown so a zero value still reads "0".
    always_comb begin
        lz_mask    = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (act_val[4*i +: 4] == 4'h0);
            lz_mask[i] = act_lz & zero_above;
        end
    end

    assign cur_hex = act_val[{idx, 2'b00} +: 4];

    hex_seg_decode u_dec (
        .hex   (cur_hex),
        .blank (lz_mask[idx]),
        .seg   (cur_seg)
    );

    always_comb begin
        an_next = '1;
        if (en_in && (cnt >= CNT_BLANK)) begin
            an_next[idx] = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            an_out         <= '1;
            cat_out        <= SEG_BLANK;
            dp_out         <= 1'b1;
            frame_done_out <= 1'b0;
        end else begin
            an_out         <= an_next;
            cat_out        <= ~cur_seg;
            dp_out         <= ~act_dp[idx];
            frame_done_out <= wrap;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
module tb_seven_seg_scan;

    localparam int ND = 4;
    localparam int CP = 8;
    localparam int BC = 2;

    logic        clk_in      = 1'b0;
    logic        rst_n_in    = 1'b1;
    logic        en_in       = 1'b0;
    logic [15:0] val_in      = '0;
    logic [3:0]  dp_in       = '0;
    logic        load_in     = 1'b0;
    logic        blank_lz_in = 1'b0;
    logic [6:0]  cat_out;
    logic        dp_out;
    logic [3:0]  an_out;
    logic        frame_done_out;

    int compared   = 0;
    int mismatched = 0;

    seven_seg_scan #(
        .NUM_DIGITS   (ND),
        .COUNT_PERIOD (CP),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .en_in          (en_in),
        .val_in         (val_in),
        .dp_in          (dp_in),
        .load_in        (load_in),
        .blank_lz_in    (blank_lz_in),
        .cat_out        (cat_out),
        .dp_out         (dp_out),
        .an_out         (an_out),
        .frame_done_out (frame_done_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_frame(output bit ok);
        int k;
        ok = 1'b0;
        k  = 0;
        while (!ok && k < 200) begin
            tick();
            if (frame_done_out === 1'b1) ok = 1'b1;
            k++;
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic lz);
        val_in      = v;
        dp_in       = dp;
        blank_lz_in = lz;
        load_in     = 1'b1;
        tick();
        load_in     = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n_in = 1'b0;
        #3;
        compared++;
        if ({an_out, cat_out, dp_out, frame_done_out} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            mismatched++;
            $display("FAIL reset_async: got an=%b cat=%h dp=%b fd=%b, want an=1111 cat=7f dp=1 fd=0",
                     an_out, cat_out, dp_out, frame_done_out);
        end
        tick();
        compared++;
        if ({an_out, cat_out, dp_out, frame_done_out} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            mismatched++;
            $display("FAIL reset_held: got an=%b cat=%h dp=%b fd=%b, want an=1111 cat=7f dp=1 fd=0",
                     an_out, cat_out, dp_out, frame_done_out);
        end
        rst_n_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            compared++;
            if ({an_out, cat_out, dp_out, frame_done_out} !== {4'hF, 7'h40, 1'b1, 1'b0}) begin
                mismatched++;
                $display("FAIL reset_idle_en0[%0d]: got an=%b cat=%h dp=%b fd=%b, want an=1111 cat=40 dp=1 fd=0",
                         k, an_out, cat_out, dp_out, frame_done_out);
            end
        end
    endtask

    task automatic test_scan();
        bit ok;
        logic [6:0]  ec [4];
        logic [3:0]  ea;
        logic [12:0] exp_v;
        ec = '{7'h0E, 7'h08, 7'h24, 7'h79};
        en_in = 1'b1;
        do_load(16'h12AF, 4'b0000, 1'b0);
        wait_frame(ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL scan_wait: frame_done=%b after 200 cycles, want 1", frame_done_out);
        end
        for (int d = 0; d < 4; d++) begin
            for (int j = 0; j < 8; j++) begin
                tick();
                ea = 4'hF;
                if (j >= BC) ea[d] = 1'b0;
                exp_v = {ea, ec[d], 1'b1, (d == 3 && j == 7)};
                compared++;
                if ({an_out, cat_out, dp_out, frame_done_out} !== exp_v) begin
                    mismatched++;
                    $display("FAIL scan d%0d j%0d: got %b, want %b", d, j,
                             {an_out, cat_out, dp_out, frame_done_out}, exp_v);
                end
            end
        end
    endtask

    task automatic test_leading_zero();
        bit ok;
        logic [6:0]  ec [4];
        logic [3:0]  ea;
        logic [12:0] exp_v;
        for (int f = 0; f < 2; f++) begin
            if (f == 0) begin
                ec = '{7'h40, 7'h30, 7'h7F, 7'h7F};
                do_load(16'h0030, 4'b0000, 1'b1);
            end else begin
                ec = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
                do_load(16'h0000, 4'b0000, 1'b1);
            end
            wait_frame(ok);
            compared++;
            if (!ok) begin
                mismatched++;
                $display("FAIL lz_wait[%0d]: frame_done=%b after 200 cycles, want 1", f, frame_done_out);
            end
            for (int d = 0; d < 4; d++) begin
                for (int j = 0; j < 8; j++) begin
                    tick();
                    ea = 4'hF;
                    if (j >= BC) ea[d] = 1'b0;
                    exp_v = {ea, ec[d], 1'b1, (d == 3 && j == 7)};
                    compared++;
                    if ({an_out, cat_out, dp_out, frame_done_out} !== exp_v) begin
                        mismatched++;
                        $display("FAIL lz[%0d] d%0d j%0d: got %b, want %b", f, d, j,
                                 {an_out, cat_out, dp_out, frame_done_out}, exp_v);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [6:0]  ecat;
        logic [3:0]  ea;
        logic [12:0] exp_v;
        do_load(16'h1111, 4'b0000, 1'b0);
        wait_frame(ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL b2b_wait: frame_done=%b after 200 cycles, want 1", frame_done_out);
        end
        for (int f = 0; f < 2; f++) begin
            ecat = (f == 0) ? 7'h79 : 7'h30;
            for (int d = 0; d < 4; d++) begin
                for (int j = 0; j < 8; j++) begin
                    load_in = (f == 0) && ((d == 1 && j == 3) || (d == 2 && j == 0));
                    if (f == 0 && d == 1) val_in = 16'h2222;
                    if (f == 0 && d == 2) val_in = 16'h3333;
                    tick();
                    load_in = 1'b0;
                    ea = 4'hF;
                    if (j >= BC) ea[d] = 1'b0;
                    exp_v = {ea, ecat, 1'b1, (d == 3 && j == 7)};
                    compared++;
                    if ({an_out, cat_out, dp_out, frame_done_out} !== exp_v) begin
                        mismatched++;
                        $display("FAIL b2b[%0d] d%0d j%0d: got %b, want %b", f, d, j,
                                 {an_out, cat_out, dp_out, frame_done_out}, exp_v);
                    end
                end
            end
        end
    endtask

    task automatic test_load_on_wrap();
        logic [3:0]  ea;
        logic [12:0] exp_v;
        for (int k = 0; k < 31; k++) tick();
        do_load(16'h5555, 4'b0000, 1'b0);
        compared++;
        if (frame_done_out !== 1'b1) begin
            mismatched++;
            $display("FAIL wrap_load_sync: frame_done=%b, want 1", frame_done_out);
        end
        for (int d = 0; d < 4; d++) begin
            for (int j = 0; j < 8; j++) begin
                tick();
                ea = 4'hF;
                if (j >= BC) ea[d] = 1'b0;
                exp_v = {ea, 7'h12, 1'b1, (d == 3 && j == 7)};
                compared++;
                if ({an_out, cat_out, dp_out, frame_done_out} !== exp_v) begin
                    mismatched++;
                    $display("FAIL wrap_load d%0d j%0d: got %b, want %b", d, j,
                             {an_out, cat_out, dp_out, frame_done_out}, exp_v);
                end
            end
        end
    endtask

    task automatic test_decimal_point();
        bit ok;
        logic [6:0]  ec [4];
        logic [3:0]  ea;
        logic [3:0]  edp_n;
        logic [12:0] exp_v;
        ec    = '{7'h79, 7'h24, 7'h30, 7'h19};
        edp_n = 4'b1010;
        do_load(16'h4321, 4'b0101, 1'b0);
        wait_frame(ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL dp_wait: frame_done=%b after 200 cycles, want 1", frame_done_out);
        end
        for (int d = 0; d < 4; d++) begin
            for (int j = 0; j < 8; j++) begin
                tick();
                ea = 4'hF;
                if (j >= BC) ea[d] = 1'b0;
                exp_v = {ea, ec[d], edp_n[d], (d == 3 && j == 7)};
                compared++;
                if ({an_out, cat_out, dp_out, frame_done_out} !== exp_v) begin
                    mismatched++;
                    $display("FAIL dp d%0d j%0d: got %b, want %b", d, j,
                             {an_out, cat_out, dp_out, frame_done_out}, exp_v);
                end
            end
        end
    endtask

    task automatic test_enable_hold();
        // From the frame start, 10 cycles puts the scan at digit 1, count 2.
        for (int k = 0; k < 10; k++) tick();
        en_in = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (k == 5) begin
                val_in  = 16'h4371;
                dp_in   = 4'b0101;
                load_in = 1'b1;
            end
            tick();
            load_in = 1'b0;
            compared++;
            if (an_out !== 4'hF || frame_done_out !== 1'b0) begin
                mismatched++;
                $display("FAIL hold[%0d]: got an=%b fd=%b, want an=1111 fd=0", k, an_out, frame_done_out);
            end
        end
        compared++;
        if (cat_out !== 7'h78 || dp_out !== 1'b1) begin
            mismatched++;
            $display("FAIL hold_load: got cat=%h dp=%b, want cat=78 dp=1", cat_out, dp_out);
        end
        en_in = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            compared++;
            if (an_out !== 4'b1101 || cat_out !== 7'h78) begin
                mismatched++;
                $display("FAIL resume[%0d]: got an=%b cat=%h, want an=1101 cat=78", k, an_out, cat_out);
            end
        end
        tick();
        compared++;
        if (an_out !== 4'hF || cat_out !== 7'h30) begin
            mismatched++;
            $display("FAIL resume_next: got an=%b cat=%h, want an=1111 cat=30", an_out, cat_out);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        logic [3:0]  ea;
        logic [12:0] exp_v;
        tick();
        tick();
        compared++;
        if (an_out !== 4'b1011) begin
            mismatched++;
            $display("FAIL pre_reset: got an=%b, want an=1011", an_out);
        end
        #2 rst_n_in = 1'b0;
        #1;
        compared++;
        if ({an_out, cat_out, dp_out, frame_done_out} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            mismatched++;
            $display("FAIL mid_reset: got an=%b cat=%h dp=%b fd=%b, want an=1111 cat=7f dp=1 fd=0",
                     an_out, cat_out, dp_out, frame_done_out);
        end
        #3 rst_n_in = 1'b1;
        wait_frame(ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL post_reset_wait: frame_done=%b after 200 cycles, want 1", frame_done_out);
        end
        for (int d = 0; d < 4; d++) begin
            for (int j = 0; j < 8; j++) begin
                tick();
                ea = 4'hF;
                if (j >= BC) ea[d] = 1'b0;
                exp_v = {ea, 7'h40, 1'b1, (d == 3 && j == 7)};
                compared++;
                if ({an_out, cat_out, dp_out, frame_done_out} !== exp_v) begin
                    mismatched++;
                    $display("FAIL post_reset d%0d j%0d: got %b, want %b", d, j,
                             {an_out, cat_out, dp_out, frame_done_out}, exp_v);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_leading_zero();
        test_back_to_back();
        test_load_on_wrap();
        test_decimal_point();
        test_enable_hold();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
- Parametrised successor to the single-digit hex-to-seven-segment decoder.
- Drives an N-digit, common-anode, time-multiplexed display from one packed hex value.
- Adds the following behaviour the single-digit decoder lacks:
  - refresh scanning;
  - inter-digit ghost blanking;
  - tear-free, frame-aligned value update;
  - leading-zero suppression;
  - per-digit decimal points;
  - a frame-done strobe.
- Sits between the system value/status registers and the board display pins.

Parameters:
- NUM_DIGITS, 8, number of digits scanned; must be ≥ 2.
- COUNT_PERIOD, 100000, clock cycles each digit slot lasts; must be ≥ 4.
- BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off (anti-ghosting); must be < COUNT_PERIOD.

Ports:
- clk_in, input, 1, system clock.
- rst_n_in, input, 1, reset; asynchronous, active-low.
- en_in, input, 1, scan enable; when low, the scan counter holds and all anodes are off.
- val_in, input, 4*NUM_DIGITS, packed hex digits; digit i = val_in[4i+3:4i], digit 0 is rightmost.
- dp_in, input, NUM_DIGITS, decimal-point request per digit, active-high.
- load_in, input, 1, one-cycle strobe that captures val_in, dp_in and blank_lz_in.
- blank_lz_in, input, 1, enables leading-zero suppression.
- cat_out, output, 7, segment cathodes {g,f,e,d,c,b,a}, active-low.
- dp_out, output, 1, decimal-point cathode, active-low.
- an_out, output, NUM_DIGITS, digit anodes, active-low, at most one low at a time.
- frame_done_out, output, 1, one-cycle pulse at the end of each full scan.

Behaviour:
- Reset (rst_n_in low, asynchronous): slot counter = 0; digit index = 0; shadow and active registers = 0; pending = 0. Outputs: an_out all ones, cat_out = 7'h7F, dp_out = 1, frame_done_out = 0.
- Slot counter: counts 0..COUNT_PERIOD-1 while en_in = 1.
  - On terminal count, the digit index increments modulo NUM_DIGITS.
  - "Wrap" = terminal count with index = NUM_DIGITS-1.
- Outputs are registered: they reflect the counter/index/active state of the previous cycle (1-cycle latency).
- an_out[idx] is low only when counter ≥ BLANK_CYCLES and en_in = 1. Otherwise all anodes are high, and cat_out/dp_out still update.
- Segment encoding (active-high gfedcba before inversion): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71. cat_out is the bitwise inverse.
- Leading-zero suppression: when the active blank flag = 1, digit i (i ≥ 1) is blanked (cat_out = 7'h7F) if digits NUM_DIGITS-1..i are all zero.
  - Digit 0 is never blanked.
  - dp_out is unaffected by blanking.
- dp_out = ~active_dp[idx].
- Update path:
  - load_in writes val_in/dp_in/blank_lz_in into the shadow register and sets pending.
  - On wrap with pending = 1, shadow is copied to active and pending clears.
  - load_in on the wrap cycle bypasses shadow and writes straight to active; pending clears.
  - While en_in = 0, a pending shadow is copied to active on the next cycle, since no frame is in progress.
- Multiple loads within one frame: the last one wins.
- frame_done_out pulses high for 1 cycle, registered, on the cycle after each wrap.
- en_in deassert mid-slot: counter and index freeze; on reassert, scanning resumes from the frozen point.
- Reset mid-frame: everything returns to reset values immediately; no partial frame is displayed.

Decomposition:
- Package seven_seg_pkg:
  - 16-entry segment lookup constant (gfedcba);
  - SEG_BLANK = 7'h7F;
  - function computing the counter width from COUNT_PERIOD.
- Sub-module hex_seg_decode: combinational 4-bit to 7-bit active-high segment lookup plus a blank input. Instantiated once on the muxed digit.
- Leading-zero mask: computed combinationally from the active register as a NUM_DIGITS-bit vector, in the top module.

Test Plan (NUM_DIGITS=4, COUNT_PERIOD=8, BLANK_CYCLES=2):
1. Reset, then en_in=1, load val=16'h12AF, dp=0 → after the next wrap, an_out cycles 1110, 1101, 1011, 0111. Each anode is low for 6 of 8 cycles. cat_out = ~71, ~77, ~5B, ~06 in turn; frame_done_out pulses every 32 cycles.
2. blank_lz_in=1, val=16'h0030 → digits 3 and 2 show cat_out=7F; digit 1 shows ~4F; digit 0 shows ~3F. val=16'h0000 → only digit 0 lit (~3F).
3. load 16'h1111, then mid-frame load 16'h2222, then 16'h3333 → the current frame completes showing 1s; the next frame shows only 3s; no mixed frame.
4. load_in asserted exactly on the wrap cycle with 16'h5555 → the next frame shows ~6D on all digits.
5. dp_in=4'b0101 → dp_out low during digit 0 and digit 2 slots only.
6. en_in low for 20 cycles mid-slot → an_out=1111 and the index holds; on resume, the slot finishes its remaining count. Asserting rst_n_in low asynchronously mid-frame → an_out=1111 and cat_out=7F with no clock edge.
